rob_complete_arbiter: RTL

//  Shares the single ROB probe/finish-write port among three completing units: 0=ALU, 1=MEM, 2=BR.

---
 rtl/rob_complete_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/rob_complete_arbiter.sv
// rob_complete_arbiter
//   Shares the single ROB probe/finish-write port among three completing
//   units (0=ALU, 1=MEM, 2=BR). One round-robin grant per cycle; the winning
//   completion is written to the ROB probe outputs from a register one cycle
//   after the handshake. A flush drops everything pending and resets priority.
// Ports
//   CLK, RESET            clock; synchronous active-low reset
//   FREEZE                global stall: no grant, no strobe, outputs held
//   FLUSH_IN              pipeline flush: no grant, no strobe, rr_ptr -> 0
//   req_valid_IN[i]       requester i holds a completion
//   req_ready_OUT[i]      requester i accepted this cycle (one-hot or 0)
//   req_idx/exp/taken/target_IN   per-requester payload, packed by requester
//   probeIdx/SetFinBit/SetExpBit/probe_taken/probe_target_OUT   ROB write
//   grantId_OUT           requester that produced the current strobe
module rob_complete_arbiter #(
    parameter int ROB_ADDRWIDTH = 6
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       FREEZE,
    input  logic                       FLUSH_IN,
    input  logic [2:0]                 req_valid_IN,
    output logic [2:0]                 req_ready_OUT,
    input  logic [3*ROB_ADDRWIDTH-1:0] req_idx_IN,
    input  logic [2:0]                 req_exp_IN,
    input  logic [2:0]                 req_taken_IN,
    input  logic [95:0]                req_target_IN,
    output logic [ROB_ADDRWIDTH-1:0]   probeIdx_OUT,
    output logic                       probeSetFinBit_OUT,
    output logic                       probeSetExpBit_OUT,
    output logic                       probe_taken_OUT,
    output logic [31:0]                probe_target_OUT,
    output logic [1:0]                 grantId_OUT
);
    localparam int NREQ = 3;
    localparam int AW   = ROB_ADDRWIDTH;

    logic [1:0] rr_ptr;
    logic       gnt_any;
    logic [1:0] gnt_id;
    logic [2:0] sum;
    logic [1:0] cand;

    // Scan rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); first valid requester wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 2'd0;
        sum     = 3'd0;
        cand    = 2'd0;
        if (RESET && !FREEZE && !FLUSH_IN) begin
            for (int k = 0; k < NREQ; k++) begin
                sum  = {1'b0, rr_ptr} + 3'(k);
                cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
                if (!gnt_any && req_valid_IN[cand]) begin
                    gnt_any = 1'b1;
                    gnt_id  = cand;
                end
            end
        end
        req_ready_OUT = gnt_any ? (3'b001 << gnt_id) : 3'b000;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rr_ptr             <= 2'd0;
            probeIdx_OUT       <= '0;
            probeSetFinBit_OUT <= 1'b0;
            probeSetExpBit_OUT <= 1'b0;
            probe_taken_OUT    <= 1'b0;
            probe_target_OUT   <= 32'd0;
            grantId_OUT        <= 2'd0;
        end else if (FLUSH_IN) begin
            probeSetFinBit_OUT <= 1'b0;
            rr_ptr             <= 2'd0;
        end else if (gnt_any) begin
            // gnt_any is already gated by FREEZE, so this only fires on a live grant
            probeSetFinBit_OUT <= 1'b1;
            probeIdx_OUT       <= req_idx_IN[gnt_id*AW +: AW];
            probeSetExpBit_OUT <= req_exp_IN[gnt_id];
            probe_taken_OUT    <= req_taken_IN[gnt_id];
            probe_target_OUT   <= req_target_IN[gnt_id*32 +: 32];
            grantId_OUT        <= gnt_id;
            rr_ptr             <= (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
        end else begin
            // idle or frozen: drop the strobe, keep payload and pointer
            probeSetFinBit_OUT <= 1'b0;
        end
    end
endmodule
